// File: rtl/ascon_pack.sv
// +----------------------------------------------------------------------------+
// | ascon_pack : shared types and round constants for the permutation control |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package ascon_pack;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] ROUND_FIRST_P12 = 4'd0;
   localparam logic [3:0] ROUND_FIRST_P6  = 4'd6;
   localparam logic [3:0] ROUND_LAST      = 4'd11;

   // p6 runs only the tail of the p12 round-constant sequence
   function automatic logic [3:0] first_round(input logic mode);
      return mode ? ROUND_FIRST_P6 : ROUND_FIRST_P12;
   endfunction

endpackage

`default_nettype wire

// File: rtl/round_counter.sv
// +----------------------------------------------------------------------------+
// | round_counter : 4-bit round index with load, enable and terminal flag     |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module round_counter
   import ascon_pack::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   input  logic       i_en,
   output logic [3:0] o_count,
   output logic       o_last
);

   logic [3:0] r_count;
   logic       w_last;

   assign w_last = (r_count == ROUND_LAST);

   // saturates at the last round so the index can never wrap
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= 4'd0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && !w_last) begin
         r_count <= r_count + 4'd1;
      end
   end

   assign o_count = r_count;
   assign o_last  = w_last;

endmodule

`default_nettype wire

// File: rtl/round_scheduler.sv
// +----------------------------------------------------------------------------+
// | round_scheduler : sequences p12/p6 rounds and state-register control      |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module round_scheduler
   import ascon_pack::*;
(
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       mode_i,
   input  logic       hold_i,
   output logic [3:0] round_o,
   output logic       sel_init_o,
   output logic       en_state_o,
   output logic       busy_o,
   output logic       done_o
);

   state_t     r_state;
   state_t     w_state_next;
   logic       r_first;
   logic       w_first_next;
   logic       w_load;
   logic       w_cnt_en;
   logic [3:0] w_count;
   logic       w_last;

   round_counter u_round_counter (
      .i_clk      (clock_i),
      .i_rst_n    (resetb_i),
      .i_load     (w_load),
      .i_load_val (first_round(mode_i)),
      .i_en       (w_cnt_en),
      .o_count    (w_count),
      .o_last     (w_last)
   );

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         r_state <= ST_IDLE;
         r_first <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_first <= w_first_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_first_next = r_first;
      w_load       = 1'b0;
      w_cnt_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_load       = 1'b1;
               w_first_next = 1'b1;
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            // a held cycle does not count as a round
            if (!hold_i) begin
               w_cnt_en     = 1'b1;
               w_first_next = 1'b0;
               if (w_last) begin
                  w_state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign round_o    = w_count;
   assign sel_init_o = (r_state == ST_RUN) && r_first;
   assign en_state_o = (r_state == ST_RUN) && !hold_i;
   assign busy_o     = (r_state != ST_IDLE);
   assign done_o     = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_round_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_round_scheduler : scoreboard bench for the round scheduler              |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_round_scheduler;

   typedef struct packed {
      logic [3:0] round;
      logic       sel;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic       hold = 1'b0;
   logic [3:0] round_o;
   logic       sel_init_o;
   logic       en_state_o;
   logic       busy_o;
   logic       done_o;

   int   cyc = 0;
   int   busy_total = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q_round[$];
   int   q_done[$];

   round_scheduler dut (
      .clock_i    (clk),
      .resetb_i   (rst_n),
      .start_i    (start),
      .mode_i     (mode),
      .hold_i     (hold),
      .round_o    (round_o),
      .sel_init_o (sel_init_o),
      .en_state_o (en_state_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // monitor: every enabled round and every done pulse is matched to the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy_o) busy_total++;
         if (en_state_o) begin
            if (q_round.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_en actual round=%0d required=no_enable (cycle %0d)", round_o, cyc);
            end else begin
               exp_t e;
               e = q_round.pop_front();
               chk("round", round_o, e.round);
               chk("sel_init", sel_init_o, e.sel);
            end
         end
         if (done_o) begin
            if (q_done.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
               int d;
               d = q_done.pop_front();
               chk("done_cycle", cyc, d);
               chk("done_en", en_state_o, 0);
               chk("done_sel", sel_init_o, 0);
            end
         end
      end
   end

   task automatic push_perm(input logic m, input int c, input int hold_len);
      int first;
      first = m ? 6 : 0;
      for (int r = first; r <= 11; r++) q_round.push_back('{round: 4'(r), sel: (r == first)});
      q_done.push_back(c + (12 - first) + 1 + hold_len);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && q_done.size() > 0; i++) @(posedge clk);
      #1;
      chk("done_timeout_left", q_done.size(), 0);
      q_done.delete();
      q_round.delete();
      @(negedge clk);
      chk("idle_busy", busy_o, 0);
      chk("idle_round_kept", round_o, 11);
   endtask

   task automatic run_perm(input logic m, input int hold_round, input int hold_len);
      int first;
      first = m ? 6 : 0;
      push_perm(m, cyc, (hold_round >= 0) ? hold_len : 0);
      start = 1'b1;
      mode  = m;
      @(posedge clk); #1;
      start = 1'b0;
      mode  = ~m;
      for (int r = first; r <= 11; r++) begin
         if (r == hold_round) begin
            hold = 1'b1;
            for (int h = 0; h < hold_len; h++) begin
               @(negedge clk);
               chk("hold_round", round_o, r);
               chk("hold_en", en_state_o, 0);
               @(posedge clk); #1;
            end
            hold = 1'b0;
         end
         @(posedge clk); #1;
      end
      wait_idle();
   endtask

   initial begin
      int b0;
      int c;

      // reset state
      #2;
      chk("rst_round", round_o, 0);
      chk("rst_sel", sel_init_o, 0);
      chk("rst_en", en_state_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      hold = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      hold = 1'b0;
      chk("idle_no_start_busy", busy_o, 0);

      // p12, no hold
      b0 = busy_total;
      run_perm(1'b0, -1, 0);
      chk("busy_p12", busy_total - b0, 13);

      // p6, no hold
      b0 = busy_total;
      run_perm(1'b1, -1, 0);
      chk("busy_p6", busy_total - b0, 7);

      // p12 with a 3-cycle stall at round 4
      b0 = busy_total;
      run_perm(1'b0, 4, 3);
      chk("busy_hold", busy_total - b0, 16);

      // start held high: one permutation, the next begins in the IDLE cycle after DONE
      c = cyc;
      push_perm(1'b0, c, 0);
      push_perm(1'b0, c + 14, 0);
      start = 1'b1;
      mode  = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      @(negedge clk);
      chk("restart_idle_busy", busy_o, 0);
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle();

      // async reset at round 7 aborts the permutation
      push_perm(1'b0, cyc, 0);
      start = 1'b1;
      mode  = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("pre_reset_round", round_o, 7);
      #1;
      rst_n = 1'b0;
      q_round.delete();
      q_done.delete();
      #1;
      chk("arst_round", round_o, 0);
      chk("arst_en", en_state_o, 0);
      chk("arst_sel", sel_init_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_done", done_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("post_abort_busy", busy_o, 0);
      b0 = busy_total;
      run_perm(1'b1, -1, 0);
      chk("busy_p6_after_reset", busy_total - b0, 7);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
